// File: rtl/pbit_hist_pkg.sv
// Shared types and default sizes for the p-bit state histogram.
package pbit_hist_pkg;

  localparam int unsigned DEF_NUM_PBITS = 8;
  localparam int unsigned DEF_CNT_W     = 32;
  localparam int unsigned DEF_LIMIT_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    DRAIN = 2'd3
  } hist_state_e;

endpackage

// File: rtl/pbit_hist_bins.sv
// Histogram bin storage: one increment port, one clear-write port, one read port.
// HIST_SATURATE_EN selects saturating bins with a sticky overflow flag; otherwise bins wrap.
module pbit_hist_bins
  import pbit_hist_pkg::*;
#(
  parameter int unsigned NUM_PBITS = DEF_NUM_PBITS,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr_en,
  input  logic [NUM_PBITS-1:0] clr_addr,
  input  logic                 inc_en,
  input  logic [NUM_PBITS-1:0] inc_addr,
  input  logic                 ovf_clr,
  input  logic [NUM_PBITS-1:0] rd_addr,
  output logic [CNT_W-1:0]     rd_data_c,
  output logic                 overflow
);

  localparam int unsigned NUM_BINS = 2**NUM_PBITS;

  logic [CNT_W-1:0] mem [NUM_BINS];
  logic [CNT_W-1:0] inc_cur;
  logic [CNT_W-1:0] inc_next;
  logic             sat_hit;

  // Read-modify-write completes in one cycle, so a hit on the same bin in the
  // following cycle always sees the previous increment (no lost counts).
  always_comb begin
    inc_cur  = mem[inc_addr];
`ifdef HIST_SATURATE_EN
    sat_hit  = inc_en & (&inc_cur);
    inc_next = (&inc_cur) ? inc_cur : inc_cur + CNT_W'(1);
`else
    sat_hit  = 1'b0;
    inc_next = inc_cur + CNT_W'(1);
`endif
  end

  assign rd_data_c = mem[rd_addr];

  // Bin contents are not reset; a new run clears them one address per cycle.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (inc_en) begin
      mem[inc_addr] <= inc_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end else if (sat_hit) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/pbit_state_histogram.sv
// Counts occurrences of each p-bit state pattern over a programmed number of samples,
// then streams every non-zero (pattern, count) pair out; build with HIST_SATURATE_EN for saturating bins.
module pbit_state_histogram
  import pbit_hist_pkg::*;
#(
  parameter int unsigned NUM_PBITS = DEF_NUM_PBITS,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned LIMIT_W   = DEF_LIMIT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LIMIT_W-1:0]   sample_limit,
  input  logic                 sample_en,
  input  logic [NUM_PBITS-1:0] state_in,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [NUM_PBITS-1:0] rd_pattern,
  output logic [CNT_W-1:0]     rd_count
);

  localparam logic [NUM_PBITS-1:0] LAST_ADDR = '1;

  hist_state_e          state_q, state_d;
  logic [NUM_PBITS-1:0] addr_q, addr_d;
  logic [LIMIT_W-1:0]   limit_q, limit_d;
  logic [LIMIT_W-1:0]   scnt_q, scnt_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 rd_valid_d;
  logic [NUM_PBITS-1:0] rd_pattern_d;
  logic [CNT_W-1:0]     rd_count_d;

  logic                 clr_en_c;
  logic                 inc_en_c;
  logic                 ovf_clr_c;
  logic                 scan_end_c;
  logic [CNT_W-1:0]     bin_data_c;

  pbit_hist_bins #(
    .NUM_PBITS (NUM_PBITS),
    .CNT_W     (CNT_W)
  ) u_bins (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_en    (clr_en_c),
    .clr_addr  (addr_q),
    .inc_en    (inc_en_c),
    .inc_addr  (state_in),
    .ovf_clr   (ovf_clr_c),
    .rd_addr   (addr_q),
    .rd_data_c (bin_data_c),
    .overflow  (overflow)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      limit_q    <= '0;
      scnt_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_pattern <= '0;
      rd_count   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      limit_q    <= limit_d;
      scnt_q     <= scnt_d;
      busy       <= busy_d;
      done       <= done_d;
      rd_valid   <= rd_valid_d;
      rd_pattern <= rd_pattern_d;
      rd_count   <= rd_count_d;
    end
  end

  // Next state and next output values; abort overrides everything.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    limit_d      = limit_q;
    scnt_d       = scnt_q;
    done_d       = 1'b0;
    rd_valid_d   = rd_valid;
    rd_pattern_d = rd_pattern;
    rd_count_d   = rd_count;
    clr_en_c     = 1'b0;
    inc_en_c     = 1'b0;
    ovf_clr_c    = 1'b0;
    scan_end_c   = 1'b0;

    if (abort) begin
      state_d    = IDLE;
      rd_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = CLEAR;
            limit_d   = sample_limit;
            scnt_d    = '0;
            addr_d    = '0;
            ovf_clr_c = 1'b1;
          end
        end

        CLEAR: begin
          clr_en_c = 1'b1;
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = (limit_q != '0) ? ACCUM : DRAIN;
          end else begin
            addr_d = addr_q + NUM_PBITS'(1);
          end
        end

        // The cycle in which the count equals the limit is spent leaving ACCUM.
        ACCUM: begin
          if (scnt_q == limit_q) begin
            state_d = DRAIN;
          end else if (sample_en) begin
            inc_en_c = 1'b1;
            scnt_d   = scnt_q + LIMIT_W'(1);
          end
        end

        // Each bin is loaded into the output registers, then held until accepted.
        DRAIN: begin
          if (rd_valid) begin
            if (rd_ready) begin
              rd_valid_d = 1'b0;
              if (addr_q == LAST_ADDR) begin
                scan_end_c = 1'b1;
              end else begin
                addr_d = addr_q + NUM_PBITS'(1);
              end
            end
          end else if (bin_data_c != '0) begin
            rd_valid_d   = 1'b1;
            rd_pattern_d = addr_q;
            rd_count_d   = bin_data_c;
          end else if (addr_q == LAST_ADDR) begin
            scan_end_c = 1'b1;
          end else begin
            addr_d = addr_q + NUM_PBITS'(1);
          end

          if (scan_end_c) begin
            state_d = IDLE;
            addr_d  = '0;
            done_d  = 1'b1;
          end
        end

        default: begin
          state_d    = IDLE;
          rd_valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_pbit_state_histogram.sv
// Directed, table-driven bench for pbit_state_histogram (3-bit states, plus a 2-bit-count instance).
module tb_pbit_state_histogram;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       start, abort, sample_en, rd_ready;
  logic [7:0] sample_limit;
  logic [2:0] state_in;
  logic       busy, done, overflow, rd_valid;
  logic [2:0] rd_pattern;
  logic [7:0] rd_count;

  logic       b_start, b_abort, b_sample_en, b_rd_ready;
  logic [7:0] b_limit;
  logic [2:0] b_state;
  logic       b_busy, b_done, b_overflow, b_rd_valid;
  logic [2:0] b_rd_pattern;
  logic [1:0] b_rd_count;

  pbit_state_histogram #(.NUM_PBITS(3), .CNT_W(8), .LIMIT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .sample_limit(sample_limit), .sample_en(sample_en), .state_in(state_in),
    .busy(busy), .done(done), .overflow(overflow), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_pattern(rd_pattern), .rd_count(rd_count)
  );

  pbit_state_histogram #(.NUM_PBITS(3), .CNT_W(2), .LIMIT_W(8)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort),
    .sample_limit(b_limit), .sample_en(b_sample_en), .state_in(b_state),
    .busy(b_busy), .done(b_done), .overflow(b_overflow), .rd_valid(b_rd_valid),
    .rd_ready(b_rd_ready), .rd_pattern(b_rd_pattern), .rd_count(b_rd_count)
  );

  typedef struct {
    int limit;
    int pats[5];
    int n_exp;
    int exp_pat[3];
    int exp_cnt[3];
  } vec_t;

  vec_t vecs[4];
  int   checks = 0;
  int   failures = 0;
  int   got_n, got_lat;
  int   got_pat[8];
  int   got_cnt[8];
  bit   got_done;
  bit   sat_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start pulse, then drive a pattern that must not count for the 8 CLEAR cycles.
  task automatic start_run(input int limit);
    @(posedge clk); #1;
    start = 1'b1; sample_limit = 8'(limit); sample_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    sample_en = 1'b1; state_in = 3'd4;
    repeat (8) @(posedge clk);
    #1 sample_en = 1'b0;
  endtask

  task automatic strobe(input int pat);
    sample_en = 1'b1; state_in = 3'(pat);
    @(posedge clk); #1 sample_en = 1'b0;
  endtask

  // Strobe during the limit-reached cycle; it must be ignored.
  task automatic tail();
    sample_en = 1'b1; state_in = 3'd4;
    @(posedge clk); #1 sample_en = 1'b0;
  endtask

  task automatic drain_collect();
    got_n = 0; got_done = 1'b0; got_lat = -1; rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin got_pat[i] = -1; got_cnt[i] = -1; end
    for (int c = 0; c < 200; c++) begin
      if (done) begin got_done = 1'b1; got_lat = c; break; end
      if (rd_valid && got_n < 8) begin
        got_pat[got_n] = int'(rd_pattern);
        got_cnt[got_n] = int'(rd_count);
        got_n++;
      end
      @(posedge clk); #1;
    end
    check("done_seen", 32'(got_done), 1);
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 40; c++) begin
      if (rd_valid) break;
      @(posedge clk); #1;
    end
    check("rd_valid_seen", 32'(rd_valid), 1);
  endtask

  task automatic no_done_window();
    int pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    check("no_done_after_abort", 32'(pulses), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef HIST_SATURATE_EN
    sat_mode = 1'b1;
`else
    sat_mode = 1'b0;
`endif
    vecs[0].limit = 5; vecs[0].pats = '{3, 3, 3, 6, 3}; vecs[0].n_exp = 2;
    vecs[0].exp_pat = '{3, 6, 0}; vecs[0].exp_cnt = '{4, 1, 0};
    vecs[1].limit = 0; vecs[1].pats = '{0, 0, 0, 0, 0}; vecs[1].n_exp = 0;
    vecs[1].exp_pat = '{0, 0, 0}; vecs[1].exp_cnt = '{0, 0, 0};
    vecs[2].limit = 4; vecs[2].pats = '{7, 0, 7, 2, 0}; vecs[2].n_exp = 3;
    vecs[2].exp_pat = '{0, 2, 7}; vecs[2].exp_cnt = '{1, 1, 2};
    vecs[3].limit = 3; vecs[3].pats = '{1, 1, 1, 0, 0}; vecs[3].n_exp = 1;
    vecs[3].exp_pat = '{1, 0, 0}; vecs[3].exp_cnt = '{3, 0, 0};

    start = 0; abort = 0; sample_en = 0; rd_ready = 1; sample_limit = 0; state_in = 0;
    b_start = 0; b_abort = 0; b_sample_en = 0; b_rd_ready = 1; b_limit = 0; b_state = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_pattern", 32'(rd_pattern), 0);
    check("rst_rd_count", 32'(rd_count), 0);
    check("rst_b_busy", 32'(b_busy), 0);
    check("rst_b_overflow", 32'(b_overflow), 0);
    reset_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      start_run(vecs[v].limit);
      if (vecs[v].limit > 0) begin
        for (int i = 0; i < vecs[v].limit; i++) strobe(vecs[v].pats[i]);
        tail();
      end
      drain_collect();
      check($sformatf("vec%0d_entries", v), 32'(got_n), 32'(vecs[v].n_exp));
      for (int i = 0; i < vecs[v].n_exp; i++) begin
        check($sformatf("vec%0d_pat%0d", v, i), 32'(got_pat[i]), 32'(vecs[v].exp_pat[i]));
        check($sformatf("vec%0d_cnt%0d", v, i), 32'(got_cnt[i]), 32'(vecs[v].exp_cnt[i]));
      end
      if (vecs[v].limit == 0) check("zero_limit_drain_cycles", 32'(got_lat), 8);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_one_cycle", v), 32'(done), 0);
      check($sformatf("vec%0d_idle", v), 32'(busy), 0);
      check($sformatf("vec%0d_overflow", v), 32'(overflow), 0);
    end

    // Back-pressure on entry (3,4).
    rd_ready = 1'b0;
    start_run(5);
    strobe(3); strobe(3); strobe(3); strobe(6); strobe(3);
    tail();
    wait_valid();
    check("bp_pattern", 32'(rd_pattern), 3);
    check("bp_count", 32'(rd_count), 4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(rd_valid), 1);
      check("bp_hold_pattern", 32'(rd_pattern), 3);
      check("bp_hold_count", 32'(rd_count), 4);
    end
    rd_ready = 1'b1;
    @(posedge clk); #1;
    drain_collect();
    check("bp_rest_entries", 32'(got_n), 1);
    check("bp_next_pattern", 32'(got_pat[0]), 6);
    check("bp_next_count", 32'(got_cnt[0]), 1);

    // Abort mid-ACCUM.
    start_run(5);
    strobe(3); strobe(3);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_accum_busy", 32'(busy), 0);
    check("abort_accum_valid", 32'(rd_valid), 0);
    check("abort_accum_done", 32'(done), 0);
    no_done_window();

    // Abort mid-DRAIN with an entry pending and ready high.
    rd_ready = 1'b0;
    start_run(1);
    strobe(3);
    tail();
    wait_valid();
    rd_ready = 1'b1; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_drain_busy", 32'(busy), 0);
    check("abort_drain_valid", 32'(rd_valid), 0);
    check("abort_drain_done", 32'(done), 0);
    no_done_window();

    // Fresh run after aborts; a start pulse while busy must be ignored.
    start_run(2);
    strobe(5);
    start = 1'b1; sample_limit = 8'd7;
    strobe(5);
    start = 1'b0;
    tail();
    drain_collect();
    check("post_abort_entries", 32'(got_n), 1);
    check("post_abort_pattern", 32'(got_pat[0]), 5);
    check("post_abort_count", 32'(got_cnt[0]), 2);

    // Asynchronous reset mid-DRAIN.
    rd_ready = 1'b0;
    start_run(1);
    strobe(2);
    tail();
    wait_valid();
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_valid", 32'(rd_valid), 0);
    check("arst_pattern", 32'(rd_pattern), 0);
    check("arst_count", 32'(rd_count), 0);
    check("arst_done", 32'(done), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    rd_ready = 1'b1;
    start_run(3);
    strobe(1); strobe(1); strobe(1);
    tail();
    drain_collect();
    check("after_rst_entries", 32'(got_n), 1);
    check("after_rst_pattern", 32'(got_pat[0]), 1);
    check("after_rst_count", 32'(got_cnt[0]), 3);

    // Seven hits on pattern 1 with 2-bit bins.
    @(posedge clk); #1 b_start = 1'b1; b_limit = 8'd7;
    @(posedge clk); #1 b_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      b_sample_en = 1'b1; b_state = 3'd1;
      @(posedge clk); #1;
    end
    b_sample_en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (b_rd_valid) break;
      @(posedge clk); #1;
    end
    check("sat_valid_seen", 32'(b_rd_valid), 1);
    check("sat_pattern", 32'(b_rd_pattern), 1);
    check("sat_count", 32'(b_rd_count), 3);
    check("sat_overflow", 32'(b_overflow), sat_mode ? 32'd1 : 32'd0);
    for (int c = 0; c < 40; c++) begin
      if (b_done) break;
      @(posedge clk); #1;
    end
    check("sat_done_seen", 32'(b_done), 1);
    check("sat_overflow_sticky", 32'(b_overflow), sat_mode ? 32'd1 : 32'd0);
    @(posedge clk); #1 b_start = 1'b1; b_limit = 8'd0;
    @(posedge clk); #1 b_start = 1'b0;
    check("sat_overflow_cleared", 32'(b_overflow), 0);
    for (int c = 0; c < 40; c++) begin
      if (b_done) break;
      @(posedge clk); #1;
    end
    check("sat_zero_run_done", 32'(b_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pbit_state_histogram.md
Name: pbit_state_histogram

Overview:
- Synthesizable on-chip histogram of p-bit network states. It counts how often each NUM_PBITS-wide state pattern occurs over a programmed number of sample strobes.
- It then streams every non-zero (pattern, count) pair out through a valid/ready port.
- Sits after the p-bit array and replaces simulation-only occurrence counting, so sampled distributions can be read out of hardware.

Parameters:
- NUM_PBITS, 8, width of the sampled state; the histogram has 2**NUM_PBITS bins.
- CNT_W, 32, width of each bin counter.
- LIMIT_W, 32, width of the programmed sample count.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
- abort  in  1  forces return to IDLE on the next edge, from any state.
- sample_limit  in  LIMIT_W  number of samples to accumulate; latched on start.
- sample_en  in  1  strobe; state_in is counted in any cycle it is high during ACCUM.
- state_in  in  NUM_PBITS  p-bit state pattern.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when drain completes.
- overflow  out  1  sticky flag (see Optional Feature).
- rd_valid  out  1  output entry valid.
- rd_ready  in  1  consumer accepts the entry.
- rd_pattern  out  NUM_PBITS  bin index of the current entry.
- rd_count  out  CNT_W  bin count of the current entry.

Behaviour:
- Reset (asynchronous) puts the block in IDLE and drives all outputs to 0. Bin contents are undefined after reset; they are cleared on the next start.
- FSM states: IDLE, CLEAR, ACCUM, DRAIN.
  - IDLE + start goes to CLEAR; sample_limit is latched and the sample counter is set to 0.
  - CLEAR zeroes one bin per cycle, address 0 to 2**NUM_PBITS-1, so it lasts exactly 2**NUM_PBITS cycles.
  - At the end of CLEAR, go to ACCUM if the latched limit is non-zero, else go straight to DRAIN.
  - In ACCUM, each cycle with sample_en=1 does bin[state_in] += 1 and sample counter += 1. The update is visible one cycle later.
  - Back-to-back strobes on the same pattern must each count; no lost increments.
  - ACCUM goes to DRAIN in the cycle after the sample counter reaches the latched limit. Further sample_en in that cycle is ignored.
  - DRAIN scans bins 0 to 2**NUM_PBITS-1 in ascending order. Zero bins are skipped at one cycle each with rd_valid=0.
  - For a non-zero bin, rd_valid=1 and rd_pattern/rd_count are held stable until rd_valid&&rd_ready, then the scan advances.
  - After the last bin is scanned or accepted: done=1 for one cycle, then IDLE.
- Bins are not cleared by DRAIN; only a new start clears them.
- start while busy is ignored.
- abort has priority over every other event, including start and a pending handshake. It takes effect on the next edge: rd_valid=0, busy=0, no done pulse.
- rd_valid never drops without a handshake, except on abort or reset.
- Arithmetic:
  - Bin counters are unsigned, CNT_W bits.
  - The sample counter is LIMIT_W bits and compares by equality.
  - The maximum limit 2**LIMIT_W-1 is valid.

Optional Feature:
- Macro: HIST_SATURATE_EN.
- Defined: a bin at 2**CNT_W-1 stays there on further hits, and overflow is set. overflow is sticky until the next start or reset.
- Undefined: bins wrap modulo 2**CNT_W and overflow is tied to 0.

Decomposition:
- Package pbit_hist_pkg:
  - hist_state_e enum (IDLE, CLEAR, ACCUM, DRAIN).
  - Default parameter constants.
- Sub-module pbit_hist_bins:
  - Bin storage with one increment port (with same-address forwarding).
  - One clear-write port and one read port.
  - Owns the saturate/wrap logic.

Test Plan:
- NUM_PBITS=3: start with sample_limit=5, feed patterns 3,3,3,6,3 on consecutive sample_en cycles. Drain emits (3,4) then (6,1), then done, busy=0; CLEAR lasts exactly 8 cycles.
- sample_limit=0: after 8 CLEAR cycles there are no rd_valid cycles, done pulses once, and the block is back in IDLE.
- rd_ready low for 10 cycles during entry (3,4): rd_pattern and rd_count stay stable and rd_valid stays high; accepting moves the scan to the next non-zero bin.
- CNT_W=2, seven hits on pattern 1:
  - With HIST_SATURATE_EN, rd_count=3 and overflow=1.
  - Without it, rd_count=3 (7 mod 4) and overflow=0.
- abort asserted mid-ACCUM, then again mid-DRAIN with rd_valid high: the next edge gives busy=0 and rd_valid=0 with no done pulse. A following run of limit 2 on pattern 5 reports only (5,2).
- reset_n pulsed low mid-DRAIN: outputs go to 0 immediately (asynchronous), the FSM is in IDLE, and start works normally afterwards.
